pipeline_stage_buffer: RTL and testbench
========================================

Name: pipeline_stage_buffer

Overview:
- Parametrised elastic buffer placed between two CPU pipeline stages: fetch→decode, decode→execute, execute→memory, memory→writeback.
- Replaces the plain stage register with a valid/ready handshake, configurable depth and a synchronous flush (branch mispredict / redirect).
- Payload is an opaque packed vector sized to the stage struct, e.g. $bits(common::decode_to_execute_t).

Parameters:
- DATA_WIDTH, 32: payload width in bits, >=1.
- DEPTH, 2: number of entries, >=1. DEPTH=1 gives a plain handshaked register; DEPTH=2 gives a full-throughput skid buffer. Need not be a power of two.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk edge
- flush  in  1  discard all held entries (pipeline redirect)
- in_valid  in  1  upstream stage offers in_data
- in_data  in  DATA_WIDTH  upstream payload
- in_ready  out  1  buffer can accept this cycle
- out_valid  out  1  out_data holds a valid entry
- out_data  out  DATA_WIDTH  oldest entry
- out_ready  in  1  downstream stage consumes this cycle
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Storage: DEPTH-entry array, write pointer wr_ptr, read pointer rd_ptr, occupancy count. Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != DEPTH) && reset_n. It depends only on registered state; there is no combinational path from out_ready. A push into a full buffer is never accepted, even if a pop happens in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr], registered. There is no fall-through: minimum latency is 1 cycle from push to out_valid.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged, both pointers advance.
- Push only: count+1. Pop only: count-1. count never exceeds DEPTH and never underflows.
- out_data is stable while out_valid && !out_ready (AXI-style hold). Upstream must keep in_data stable while in_valid && !in_ready. The buffer does not check this.
- Flush: takes effect at the clock edge. wr_ptr, rd_ptr and count go to 0. Any push or pop presented in the flush cycle is discarded and has no effect. out_valid=0 on the next cycle. in_ready stays 1 during flush when not full, but the accepted data is dropped.
- Reset (reset_n=0 at an edge): wr_ptr=0, rd_ptr=0, count=0, so out_valid=0 next cycle. in_ready=0 while reset_n is low. Memory contents are not reset. out_data is don't-care while out_valid=0.
- Reset mid-operation behaves exactly like flush plus the in_ready gating. Reset has priority over flush.
- Throughput: with DEPTH>=2, one transfer per cycle is sustained indefinitely. With DEPTH=1, at most one transfer every 2 cycles.

Optional Feature:
- Macro: PIPELINE_STAGE_BUFFER_STATS_EN.
- When defined, adds two outputs:
  - stall_cycles [31:0]: increments each cycle with in_valid && !in_ready.
  - bubble_cycles [31:0]: increments each cycle with out_ready && !out_valid.
- Both counters saturate at 32'hFFFF_FFFF, reset to 0 on reset_n=0, and are not cleared by flush.
- When undefined, neither port nor the counter logic exists.

Decomposition:
- Package common gets:
  - localparam PIPE_BUFFER_DEFAULT_DEPTH = 2.
  - typedef struct packed {logic [31:0] stall_cycles; logic [31:0] bubble_cycles;} pipe_buffer_stats_t, used by the stats port bundle when the macro is set.
- Sub-module wrap_counter (parameter MAX; inputs clk, reset_n, clear, inc; output value) is instantiated twice, for wr_ptr and rd_ptr. It wraps MAX-1→0, and clear/reset force 0.

Test Plan:
- DEPTH=2: push 32'hA, 32'hB in consecutive cycles with out_ready=0 → count=2, in_ready=0. out_data=32'hA stays stable for 5 cycles. Raise out_ready → A then B emerge, then out_valid=0.
- DEPTH=2: in_valid=1 and out_ready=1 continuously with incrementing data 0..99 → 100 beats out in order, no gaps after first output, count stays ≤1.
- DEPTH=3: fill to 3, pop 1, push 1 → wr_ptr wraps to 0 (DEPTH not a power of two), FIFO order preserved.
- Full buffer, in_valid=1, out_ready=1 same cycle → one pop occurs, push is rejected, count=2 next cycle.
- count=2: assert flush with in_valid=1 → next cycle count=0, out_valid=0, the pushed data never appears. Assert reset_n=0 mid-stream → in_ready=0 during reset, count=0 afterwards.
- STATS_EN: hold full with in_valid=1 for 7 cycles → stall_cycles=7. Out_ready=1 on empty for 4 cycles → bubble_cycles=4. Preload the counter to near max via a force → saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared types and constants for the pipeline stage buffer.
//   PIPE_BUFFER_DEFAULT_DEPTH : default entry count (two entries sustain full throughput)
//   pipe_buffer_stats_t       : bundle for the optional stall/bubble counters
//   sat_inc                   : 32-bit increment that sticks at all-ones
package pipeline_stage_buffer_pkg;

  localparam int PIPE_BUFFER_DEFAULT_DEPTH = 2;

  typedef struct packed {
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
  } pipe_buffer_stats_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_stage_buffer_if.sv
// Handshake bundle between two pipeline stages through the stage buffer.
//   in_valid/in_data/in_ready    : upstream push side
//   out_valid/out_data/out_ready : downstream pop side
//   count                        : buffer occupancy
// master: the stage(s) around the buffer; slave: the buffer itself.
interface pipeline_stage_buffer_if
  import pipeline_stage_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = PIPE_BUFFER_DEFAULT_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CW-1:0]         count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipeline_stage_buffer_wrap_counter.sv
// Wrap counter used for the buffer read/write pointers.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : synchronous clear (flush), same effect as reset
//   inc          : advance by one, wrapping MAX-1 -> 0
//   value        : current pointer
// MAX need not be a power of two, so the wrap is an explicit compare.
module pipeline_stage_buffer_wrap_counter #(
  parameter  int MAX = 2,
  localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset_n || clear)
      value <= '0;
    else if (inc)
      value <= (value == W'(MAX - 1)) ? '0 : value + 1'b1;
  end

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Elastic valid/ready buffer between two CPU pipeline stages.
//   clk, reset_n : clock, synchronous active-low reset
//   flush        : drop all held entries (redirect); push/pop in that cycle ignored
//   bus (slave)  : in_valid/in_data/in_ready, out_valid/out_data/out_ready, count
//   stats        : stall/bubble counters, only with PIPELINE_STAGE_BUFFER_STATS_EN
// in_ready is a function of registered state only (no out_ready path), so a
// full buffer refuses a push even while it is being popped. No fall-through:
// a pushed entry is visible on out_data one cycle later at the earliest.
module pipeline_stage_buffer
  import pipeline_stage_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = PIPE_BUFFER_DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  pipeline_stage_buffer_if.slave       bus
`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
  ,
  output pipe_buffer_stats_t           stats
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  push, pop;

  assign bus.in_ready  = (count_q != CW'(DEPTH)) && reset_n;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  pipeline_stage_buffer_wrap_counter #(.MAX(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (push),
    .value   (wr_ptr)
  );

  pipeline_stage_buffer_wrap_counter #(.MAX(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .inc     (pop),
    .value   (rd_ptr)
  );

  // Storage is not reset; out_data is only meaningful while out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush)
      count_q <= '0;
    else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
  logic [31:0] stall_q, bubble_q;

  // Flush does not clear these; only reset does.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (bus.in_valid && !bus.in_ready)
        stall_q <= sat_inc(stall_q);
      if (bus.out_ready && !bus.out_valid)
        bubble_q <= sat_inc(bubble_q);
    end
  end

  assign stats.stall_cycles  = stall_q;
  assign stats.bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Self-checking bench for pipeline_stage_buffer: DEPTH=2 and DEPTH=3 instances,
// directed scenarios plus a randomized run against a queue model.
// Build with PIPELINE_STAGE_BUFFER_STATS_EN to also exercise the counters.
module tb_pipeline_stage_buffer;
  import pipeline_stage_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic flush2, flush3;
  int   checks = 0;
  int   errors = 0;

  pipeline_stage_buffer_if #(.DATA_WIDTH(32), .DEPTH(2)) b2 ();
  pipeline_stage_buffer_if #(.DATA_WIDTH(32), .DEPTH(3)) b3 ();

`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
  pipe_buffer_stats_t stats2, stats3;
`endif

  pipeline_stage_buffer #(.DATA_WIDTH(32), .DEPTH(2)) u2 (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush2),
    .bus     (b2.slave)
`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
    , .stats (stats2)
`endif
  );

  pipeline_stage_buffer #(.DATA_WIDTH(32), .DEPTH(3)) u3 (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush3),
    .bus     (b3.slave)
`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
    , .stats (stats3)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge; sample and drive 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    b2.in_valid = 1'b1;
    b3.in_valid = 1'b1;
    #1;
    checks++; if (b2.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready2: got %b want 0", b2.in_ready); end
    checks++; if (b3.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready3: got %b want 0", b3.in_ready); end
    tick(); tick();
    checks++; if (b2.count !== 2'd0 || b2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_state2: count %0d valid %b want 0 0", b2.count, b2.out_valid); end
    checks++; if (b3.count !== 2'd0 || b3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_state3: count %0d valid %b want 0 0", b3.count, b3.out_valid); end
    reset_n = 1'b1;
    b2.in_valid = 1'b0;
    b3.in_valid = 1'b0;
    #1;
    checks++; if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", b2.in_ready); end
  endtask

  task automatic test_hold();
    b2.out_ready = 1'b0;
    b2.in_valid  = 1'b1;
    b2.in_data   = 32'hA;
    tick();
    checks++; if (b2.count !== 2'd1) begin errors++; $display("FAIL hold_count1: got %0d want 1", b2.count); end
    b2.in_data = 32'hB;
    tick();
    b2.in_valid = 1'b0;
    checks++; if (b2.count !== 2'd2 || b2.in_ready !== 1'b0) begin errors++; $display("FAIL hold_full: count %0d ready %b want 2 0", b2.count, b2.in_ready); end
    checks++; if (b2.out_valid !== 1'b1 || b2.out_data !== 32'hA) begin errors++; $display("FAIL hold_head: valid %b data %h want 1 0000000a", b2.out_valid, b2.out_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (b2.out_valid !== 1'b1 || b2.out_data !== 32'hA) begin errors++; $display("FAIL hold_stable[%0d]: valid %b data %h want 1 0000000a", i, b2.out_valid, b2.out_data); end
    end
    b2.out_ready = 1'b1;
    tick();
    checks++; if (b2.out_valid !== 1'b1 || b2.out_data !== 32'hB || b2.count !== 2'd1) begin errors++; $display("FAIL hold_second: valid %b data %h count %0d want 1 0000000b 1", b2.out_valid, b2.out_data, b2.count); end
    tick();
    checks++; if (b2.out_valid !== 1'b0 || b2.count !== 2'd0) begin errors++; $display("FAIL hold_empty: valid %b count %0d want 0 0", b2.out_valid, b2.count); end
    b2.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int next_in = 0, next_out = 0, gaps = 0, maxc = 0, cyc = 0;
    bit started = 0, acc, fire;
    b2.in_valid  = 1'b1;
    b2.out_ready = 1'b1;
    b2.in_data   = 32'd0;
    while (next_out < 100 && cyc < 400) begin
      acc  = b2.in_ready;
      fire = b2.out_valid;
      if (fire) begin
        checks++; if (b2.out_data !== 32'(next_out)) begin errors++; $display("FAIL stream_order: got %0d want %0d", b2.out_data, next_out); end
        next_out++;
        started = 1;
      end else if (started) gaps++;
      if (int'(b2.count) > maxc) maxc = int'(b2.count);
      tick();
      cyc++;
      if (acc) begin
        next_in++;
        b2.in_data = 32'(next_in);
      end
      if (next_in >= 100) b2.in_valid = 1'b0;
    end
    b2.in_valid  = 1'b0;
    b2.out_ready = 1'b0;
    checks++; if (next_out != 100) begin errors++; $display("FAIL stream_timeout: got %0d beats want 100", next_out); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
    checks++; if (maxc > 1) begin errors++; $display("FAIL stream_maxcount: got %0d want <=1", maxc); end
    tick();
    checks++; if (b2.count !== 2'd0) begin errors++; $display("FAIL stream_drained: count %0d want 0", b2.count); end
  endtask

  task automatic test_wrap_depth3();
    logic [31:0] exp_q[$];
    b3.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b3.in_valid = 1'b1;
      b3.in_data  = 32'(i);
      tick();
    end
    b3.in_valid = 1'b0;
    checks++; if (b3.count !== 2'd3 || b3.in_ready !== 1'b0 || b3.out_data !== 32'd1) begin errors++; $display("FAIL wrap_full: count %0d ready %b data %0d want 3 0 1", b3.count, b3.in_ready, b3.out_data); end
    b3.out_ready = 1'b1;
    tick();
    b3.out_ready = 1'b0;
    checks++; if (b3.count !== 2'd2 || b3.out_data !== 32'd2 || b3.in_ready !== 1'b1) begin errors++; $display("FAIL wrap_pop: count %0d data %0d ready %b want 2 2 1", b3.count, b3.out_data, b3.in_ready); end
    b3.in_valid = 1'b1;
    b3.in_data  = 32'd4;
    tick();
    checks++; if (b3.count !== 2'd3) begin errors++; $display("FAIL wrap_refill: count %0d want 3", b3.count); end
    // Full with push and pop together: pop happens, push refused.
    b3.in_data   = 32'd99;
    b3.out_ready = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    checks++; if (b3.count !== 2'd2 || b3.out_data !== 32'd3) begin errors++; $display("FAIL full_pushpop: count %0d data %0d want 2 3", b3.count, b3.out_data); end
    exp_q = '{32'd3, 32'd4};
    foreach (exp_q[i]) begin
      checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== exp_q[i]) begin errors++; $display("FAIL wrap_drain[%0d]: valid %b data %0d want 1 %0d", i, b3.out_valid, b3.out_data, exp_q[i]); end
      tick();
    end
    b3.out_ready = 1'b0;
    checks++; if (b3.out_valid !== 1'b0 || b3.count !== 2'd0) begin errors++; $display("FAIL wrap_empty: valid %b count %0d want 0 0", b3.out_valid, b3.count); end
  endtask

  task automatic test_flush();
    b2.in_valid = 1'b1; b2.in_data = 32'd11; tick();
    b2.in_data = 32'd12; tick();
    checks++; if (b2.count !== 2'd2) begin errors++; $display("FAIL flush_fill: count %0d want 2", b2.count); end
    flush2 = 1'b1; b2.in_data = 32'd55; b2.out_ready = 1'b1;
    tick();
    flush2 = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b0;
    checks++; if (b2.count !== 2'd0 || b2.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full: count %0d valid %b want 0 0", b2.count, b2.out_valid); end
    tick(); tick();
    checks++; if (b2.count !== 2'd0 || b2.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: count %0d valid %b want 0 0", b2.count, b2.out_valid); end
    b2.in_valid = 1'b1; b2.in_data = 32'd21; tick();
    flush2 = 1'b1; b2.in_data = 32'd22;
    #1;
    checks++; if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", b2.in_ready); end
    tick();
    flush2 = 1'b0; b2.in_valid = 1'b0;
    checks++; if (b2.count !== 2'd0 || b2.out_valid !== 1'b0) begin errors++; $display("FAIL flush_partial: count %0d valid %b want 0 0", b2.count, b2.out_valid); end
    b2.in_valid = 1'b1; b2.in_data = 32'd23; tick();
    b2.in_valid = 1'b0;
    checks++; if (b2.count !== 2'd1 || b2.out_data !== 32'd23) begin errors++; $display("FAIL flush_resume: count %0d data %0d want 1 23", b2.count, b2.out_data); end
    b2.out_ready = 1'b1; tick(); b2.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    b2.in_valid = 1'b1; b2.in_data = 32'd31; tick();
    b2.in_data = 32'd32; tick();
    reset_n = 1'b0; b2.in_data = 32'd33;
    #1;
    checks++; if (b2.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", b2.in_ready); end
    tick();
    checks++; if (b2.count !== 2'd0 || b2.out_valid !== 1'b0 || b2.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state: count %0d valid %b ready %b want 0 0 0", b2.count, b2.out_valid, b2.in_ready); end
    reset_n = 1'b1; b2.in_valid = 1'b0;
    #1;
    checks++; if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release: got %b want 1", b2.in_ready); end
    tick();
    checks++; if (b2.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty: valid %b want 0", b2.out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    bit mpush, mpop, fl;
    logic [31:0] d;
    for (int cyc = 0; cyc < 500; cyc++) begin
      checks++; if (b2.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, b2.out_valid, q.size() != 0); end
      checks++; if (b2.in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, b2.in_ready, q.size() < 2); end
      checks++; if (b2.count !== 2'(q.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, b2.count, q.size()); end
      if (q.size() != 0) begin
        checks++; if (b2.out_data !== q[0]) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, b2.out_data, q[0]); end
      end
      d  = $urandom;
      fl = ($urandom_range(0, 19) == 0);
      b2.in_valid  = ($urandom_range(0, 3) != 0);
      b2.in_data   = d;
      b2.out_ready = ($urandom_range(0, 2) != 0);
      flush2       = fl;
      mpush = b2.in_valid && (q.size() < 2);
      mpop  = b2.out_ready && (q.size() > 0);
      tick();
      if (fl) q.delete();
      else begin
        if (mpop) void'(q.pop_front());
        if (mpush) q.push_back(d);
      end
    end
    b2.in_valid = 1'b0; b2.out_ready = 1'b0; flush2 = 1'b0;
  endtask

`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    checks++; if (stats2 !== '0) begin errors++; $display("FAIL stats_reset: got %h want 0", stats2); end
    b2.in_valid = 1'b1; b2.in_data = 32'd1; tick(); tick();
    repeat (7) tick();
    b2.in_valid = 1'b0;
    checks++; if (stats2.stall_cycles !== 32'd7 || stats2.bubble_cycles !== 32'd0) begin errors++; $display("FAIL stats_stall: got %0d/%0d want 7/0", stats2.stall_cycles, stats2.bubble_cycles); end
    b2.out_ready = 1'b1; tick(); tick();
    repeat (4) tick();
    b2.out_ready = 1'b0;
    checks++; if (stats2.bubble_cycles !== 32'd4) begin errors++; $display("FAIL stats_bubble: got %0d want 4", stats2.bubble_cycles); end
    flush2 = 1'b1; tick(); flush2 = 1'b0;
    checks++; if (stats2.stall_cycles !== 32'd7) begin errors++; $display("FAIL stats_flush: got %0d want 7", stats2.stall_cycles); end
    b2.in_valid = 1'b1; tick(); tick();
    force u2.stall_q = 32'hFFFF_FFFD;
    #1;
    release u2.stall_q;
    repeat (5) tick();
    b2.in_valid = 1'b0;
    checks++; if (stats2.stall_cycles !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_saturate: got %h want ffffffff", stats2.stall_cycles); end
    reset_n = 1'b0; tick(); reset_n = 1'b1;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    flush2 = 1'b0; flush3 = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
    tick();
    test_reset();
    test_hold();
    test_back_to_back();
    test_wrap_depth3();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef PIPELINE_STAGE_BUFFER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
